// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-ported data memory between the MIPS core data port (cpu_*)
// and a loader/debug port (ld_*) used to preload or dump memory.
//
// Arbitration summary:
//   - The CPU wins by default and never holds ownership; every CPU beat is
//     arbitrated on its own.
//   - A loader that has been refused for MAXWAIT cycles in a row wins the next
//     tie, bounding its latency to MAXWAIT+1 cycles.
//   - A granted loader beat that is not the last one opens a burst (LD_BURST).
//     The loader then owns the port until ld_last, BURST_MAX beats, or until it
//     drops ld_req, which bounds the CPU stall to BURST_MAX cycles.
//   - When loader ownership ends, prefer_cpu gives the CPU the very next tie.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   cpu_req/we/addr/wdata core beat request (address passed through unchanged)
//   cpu_gnt               core beat accepted this cycle (combinational)
//   cpu_rvalid            rdata holds the core's read data (cycle after grant)
//   ld_req/we/addr/wdata  loader beat request
//   ld_last               final beat of the loader burst
//   ld_gnt                loader beat accepted this cycle (combinational)
//   ld_rvalid             rdata holds the loader's read data (cycle after grant)
//   rdata                 shared read data, equal to mem_rdata
//   mem_we/addr/wdata     memory strobe, address and write data; all zero when
//                         nobody is granted
//   mem_rdata             synchronous-read memory data
//   stall                 core requested but was refused this cycle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAXWAIT   = 4,
  parameter int BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  // core data port
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  // loader / debug port
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          ld_last,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  // shared read data
  output logic [DW-1:0] rdata,
  // memory side
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // core hold
  output logic          stall
);

  localparam int WW = $clog2(MAXWAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAXWAIT);
  localparam logic [WW-1:0] WAIT_ONE   = WW'(1);
  localparam logic [BW-1:0] BEAT_LIMIT = BW'(BURST_MAX);
  localparam logic [BW-1:0] BEAT_ONE   = BW'(1);
  localparam logic          MULTI_BEAT = (BURST_MAX > 1);

  typedef enum logic {
    IDLE     = 1'b0,
    LD_BURST = 1'b1
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] beat_cnt;
  logic          prefer_cpu;

  logic          ld_wins_tie;
  logic          burst_last;

  // Saturating increment of the loader wait counter.
  function automatic logic [WW-1:0] wait_sat_inc(input logic [WW-1:0] cnt);
    if (cnt >= WAIT_LIMIT) begin
      return WAIT_LIMIT;
    end
    return cnt + WAIT_ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // Grant decision (combinational, same cycle as the request)
  // ---------------------------------------------------------------------------
  always_comb begin
    cpu_gnt     = 1'b0;
    ld_gnt      = 1'b0;
    // prefer_cpu overrides an expired wait, so the CPU always gets one beat
    // between loader ownerships.
    ld_wins_tie = ~prefer_cpu & (wait_cnt == WAIT_LIMIT);
    if (reset) begin
      if (state == LD_BURST) begin
        ld_gnt = ld_req;
      end else if (cpu_req && ld_req) begin
        ld_gnt  = ld_wins_tie;
        cpu_gnt = ~ld_wins_tie;
      end else begin
        cpu_gnt = cpu_req;
        ld_gnt  = ld_req;
      end
    end
  end

  assign stall = reset & cpu_req & ~cpu_gnt;

  // The current beat closes the burst on ld_last or when the beat budget is used.
  assign burst_last = ld_last | ((beat_cnt + BEAT_ONE) == BEAT_LIMIT);

  // Memory port mux: idle bus is driven to zero so a stray strobe cannot leak.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  assign rdata = mem_rdata;

  // ---------------------------------------------------------------------------
  // Ownership state, counters and read-valid tracking (registered)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      beat_cnt   <= '0;
      prefer_cpu <= 1'b0;
      cpu_rvalid <= 1'b0;
      ld_rvalid  <= 1'b0;
    end else begin
      // Memory read is synchronous: data appears the cycle after the grant.
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      ld_rvalid  <= ld_gnt & ~ld_we;

      // prefer_cpu is a one-cycle pulse unless re-armed below.
      prefer_cpu <= 1'b0;

      if (ld_req && !ld_gnt) begin
        wait_cnt <= wait_sat_inc(wait_cnt);
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (ld_gnt) begin
            if (!ld_last && MULTI_BEAT) begin
              state    <= LD_BURST;
              beat_cnt <= BEAT_ONE;
            end else begin
              prefer_cpu <= 1'b1;
            end
          end
        end
        LD_BURST: begin
          if (ld_req) begin
            if (burst_last) begin
              state      <= IDLE;
              beat_cnt   <= '0;
              prefer_cpu <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + BEAT_ONE;
            end
          end else begin
            // Abandoned burst: ownership is released and the CPU still gets
            // the next tie.
            state      <= IDLE;
            beat_cnt   <= '0;
            prefer_cpu <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
